// File: rtl/mac_sample_sequencer_pkg.sv
// Shared types and helpers for the MAC sample sequencer: FSM state encoding,
// a constant-evaluable ceiling log2 and the drop counter width.
package mac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } seq_state_t;

  localparam int DROP_CNT_W = 8;

  function automatic int CeilLog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mac_sample_sequencer_if.sv
// Sample-in / MAC-out bundle of the sequencer. The master side feeds ADC samples,
// the slave side is the sequencer. drop_count exists only with SEQ_DROP_COUNT_EN.
interface mac_sample_sequencer_if
  import mac_seq_pkg::*;
#(
  parameter int WORD_LENGTH = 16,
  parameter int NUM_TAPS    = 32
);

  logic [WORD_LENGTH-1:0]        in_data;
  logic                          in_strobe;
  logic                          clear_ovf;
  logic [WORD_LENGTH-1:0]        mac_data;
  logic                          mac_enable;
  logic                          mac_sync_reset;
  logic [CeilLog2(NUM_TAPS)-1:0] tap_index;
  logic                          busy;
  logic                          overflow;
`ifdef SEQ_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0]         drop_count;
`endif

  modport master (
`ifdef SEQ_DROP_COUNT_EN
    input  drop_count,
`endif
    output in_data, in_strobe, clear_ovf,
    input  mac_data, mac_enable, mac_sync_reset, tap_index, busy, overflow
  );

  modport slave (
`ifdef SEQ_DROP_COUNT_EN
    output drop_count,
`endif
    input  in_data, in_strobe, clear_ovf,
    output mac_data, mac_enable, mac_sync_reset, tap_index, busy, overflow
  );

endinterface

// File: rtl/mac_sample_sequencer_fifo.sv
// Register-based sample FIFO. A push while full is accepted only when a pop
// frees the head slot in the same cycle.
module sample_fifo
  import mac_seq_pkg::*;
#(
  parameter int WORD_LENGTH = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  logic                                pop,
  input  logic [WORD_LENGTH-1:0]              din,
  output logic [WORD_LENGTH-1:0]              dout,
  output logic                                empty,
  output logic                                full,
  output logic [CeilLog2(FIFO_DEPTH):0]       count
);

  localparam int PTR_W = CeilLog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WORD_LENGTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_sample_sequencer.sv
// Buffers ADC samples and replays each one to the FIR MAC for NUM_TAPS enable
// cycles followed by a frame pulse. Optional SEQ_DROP_COUNT_EN adds drop_count.
module mac_sample_sequencer
  import mac_seq_pkg::*;
#(
  parameter int WORD_LENGTH = 16,
  parameter int NUM_TAPS    = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  mac_sample_sequencer_if.slave  bus
);

  localparam int TAP_W = CeilLog2(NUM_TAPS);
  localparam int CNT_W = CeilLog2(FIFO_DEPTH) + 1;
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);

  seq_state_t             state;
  logic [TAP_W-1:0]       tap_count;
  logic [WORD_LENGTH-1:0] mac_data_q;
  logic                   enable_q;
  logic                   sync_q;
  logic                   overflow_q;

  logic [WORD_LENGTH-1:0] fifo_dout;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [CNT_W-1:0]       fifo_count;
  logic                   pop;
  logic                   drop;

  assign pop  = (state == LOAD);
  assign drop = bus.in_strobe && fifo_full && !pop;

  sample_fifo #(
    .WORD_LENGTH (WORD_LENGTH),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.in_strobe),
    .pop   (pop),
    .din   (bus.in_data),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // The tap counter is zero outside RUN, so it drives tap_index directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tap_count  <= '0;
      mac_data_q <= '0;
      enable_q   <= 1'b0;
      sync_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) state <= LOAD;
        end
        LOAD: begin
          mac_data_q <= fifo_dout;
          tap_count  <= '0;
          enable_q   <= 1'b1;
          state      <= RUN;
        end
        RUN: begin
          if (tap_count == TAP_LAST) begin
            tap_count <= '0;
            enable_q  <= 1'b0;
            sync_q    <= 1'b1;
            state     <= FLUSH;
          end else begin
            tap_count <= tap_count + TAP_W'(1);
          end
        end
        FLUSH: begin
          sync_q <= 1'b0;
          state  <= fifo_empty ? IDLE : LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A drop in the same cycle as clear_ovf keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.clear_ovf) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef SEQ_DROP_COUNT_EN
  logic [DROP_CNT_W-1:0] drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (bus.clear_ovf) begin
      drop_q <= drop ? DROP_CNT_W'(1) : '0;
    end else if (drop && (drop_q != '1)) begin
      drop_q <= drop_q + DROP_CNT_W'(1);
    end
  end

  assign bus.drop_count = drop_q;
`endif

  assign bus.mac_data       = mac_data_q;
  assign bus.mac_enable     = enable_q;
  assign bus.mac_sync_reset = sync_q;
  assign bus.tap_index      = tap_count;
  assign bus.overflow       = overflow_q;
  assign bus.busy           = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_mac_sample_sequencer.sv
// Self-checking bench for mac_sample_sequencer: directed scenarios plus random
// strobes, checked every cycle against a frame-schedule reference model.
module tb_mac_sample_sequencer;
  import mac_seq_pkg::*;

  localparam int WL    = 16;
  localparam int NT    = 32;
  localparam int FD    = 4;
  localparam int FRAME = NT + 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  mac_sample_sequencer_if #(.WORD_LENGTH(WL), .NUM_TAPS(NT)) bus ();

  mac_sample_sequencer #(
    .WORD_LENGTH (WL),
    .NUM_TAPS    (NT),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int t      = 0;
  bit in_reset = 1'b1;

  // Reference model: each accepted sample gets a LOAD edge; frames follow from it.
  int          frame_load[$];
  logic [WL-1:0] frame_val[$];
  int          pend_pop[$];
  int          last_load;
  bit          ovf_m;
  int          drop_m;

  int exp_en, exp_sync, exp_tap, exp_busy;
  logic [WL-1:0] exp_data;
  int en_cycles, sync_cycles, first_en_t;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, t, obs, exp);
    end
  endtask

  task automatic modelReset();
    frame_load.delete();
    frame_val.delete();
    pend_pop.delete();
    last_load = -1000;
    ovf_m     = 1'b0;
    drop_m    = 0;
  endtask

  task automatic modelEdge(input bit strobe, input logic [WL-1:0] data, input bit clr);
    bit pop_now, accept, drop;
    int ld;
    pop_now = (pend_pop.size() > 0) && (pend_pop[0] == t);
    accept  = strobe && ((pend_pop.size() < FD) || pop_now);
    drop    = strobe && !accept;
    if (pop_now) void'(pend_pop.pop_front());
    if (accept) begin
      ld = (last_load + FRAME > t + 1) ? last_load + FRAME : t + 1;
      last_load = ld;
      frame_load.push_back(ld);
      frame_val.push_back(data);
      pend_pop.push_back(ld + 1);
    end
    if (drop) ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    if (clr) drop_m = drop ? 1 : 0;
    else if (drop && drop_m < 255) drop_m++;
  endtask

  task automatic computeExpected();
    bit active;
    exp_en = 0; exp_sync = 0; exp_tap = 0; exp_data = '0; active = 1'b0;
    foreach (frame_load[i]) begin
      int ld;
      ld = frame_load[i];
      if (ld + 1 <= t) exp_data = frame_val[i];
      if (t >= ld && t <= ld + NT + 1) active = 1'b1;
      if (t >= ld + 1 && t <= ld + NT) begin
        exp_en  = 1;
        exp_tap = t - ld - 1;
      end
      if (t == ld + NT + 1) exp_sync = 1;
    end
    exp_busy = (active || pend_pop.size() > 0) ? 1 : 0;
  endtask

  task automatic applyStimulus(input bit strobe, input logic [WL-1:0] data, input bit clr);
    bus.in_strobe = strobe;
    bus.in_data   = data;
    bus.clear_ovf = clr;
    @(posedge clk);
    t++;
    if (!in_reset) modelEdge(strobe, data, clr);
    @(negedge clk);
    computeExpected();
    if (bus.mac_enable) begin
      en_cycles++;
      if (first_en_t < 0) first_en_t = t;
    end
    if (bus.mac_sync_reset) sync_cycles++;
    checkOutput("mac_enable", 32'(bus.mac_enable), 32'(exp_en));
    checkOutput("mac_sync_reset", 32'(bus.mac_sync_reset), 32'(exp_sync));
    checkOutput("tap_index", 32'(bus.tap_index), 32'(exp_tap));
    checkOutput("mac_data", 32'(bus.mac_data), 32'(exp_data));
    checkOutput("busy", 32'(bus.busy), 32'(exp_busy));
    checkOutput("overflow", 32'(bus.overflow), 32'(ovf_m));
`ifdef SEQ_DROP_COUNT_EN
    checkOutput("drop_count", 32'(bus.drop_count), 32'(drop_m));
`endif
    checkOutput("en_sync_exclusive", 32'(bus.mac_enable & bus.mac_sync_reset), 32'd0);
    bus.in_strobe = 1'b0;
    bus.clear_ovf = 1'b0;
  endtask

  task automatic drainIdle(input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      applyStimulus(1'b0, '0, 1'b0);
      done = !bus.busy;
    end
    checkOutput("drain_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic resetCounters();
    en_cycles   = 0;
    sync_cycles = 0;
    first_en_t  = -1;
  endtask

  initial begin
    int t0;
    bit hit;
    bus.in_strobe = 1'b0;
    bus.in_data   = '0;
    bus.clear_ovf = 1'b0;
    modelReset();
    resetCounters();

    $display("[TB] reset state");
    repeat (2) applyStimulus(1'b0, '0, 1'b0);
    reset    = 1'b1;
    in_reset = 1'b0;
    repeat (2) applyStimulus(1'b0, '0, 1'b0);

    $display("[TB] single strobe");
    resetCounters();
    applyStimulus(1'b1, 16'h1234, 1'b0);
    t0 = t;
    drainIdle(60);
    checkOutput("single_latency", 32'(first_en_t - t0), 32'd2);
    checkOutput("single_en_cycles", 32'(en_cycles), 32'(NT));
    checkOutput("single_sync_cycles", 32'(sync_cycles), 32'd1);

    $display("[TB] three back-to-back strobes");
    resetCounters();
    applyStimulus(1'b1, 16'hAAAA, 1'b0);
    applyStimulus(1'b1, 16'hBBBB, 1'b0);
    applyStimulus(1'b1, 16'hCCCC, 1'b0);
    drainIdle(4 * FRAME);
    checkOutput("three_en_cycles", 32'(en_cycles), 32'(3 * NT));
    checkOutput("three_sync_cycles", 32'(sync_cycles), 32'd3);

    $display("[TB] six strobes, overflow and clear");
    resetCounters();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, WL'(16'h6000 + i), 1'b0);
    checkOutput("six_overflow", 32'(bus.overflow), 32'd1);
`ifdef SEQ_DROP_COUNT_EN
    checkOutput("six_drop_count", 32'(bus.drop_count), 32'd1);
`endif
    applyStimulus(1'b1, 16'h6FFF, 1'b1);
    checkOutput("clear_with_drop", 32'(bus.overflow), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("clear_alone", 32'(bus.overflow), 32'd0);
    drainIdle(6 * FRAME);
    checkOutput("six_en_cycles", 32'(en_cycles), 32'(5 * NT));

    $display("[TB] reset during RUN");
    resetCounters();
    applyStimulus(1'b1, 16'hBEEF, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      applyStimulus(1'b0, '0, 1'b0);
      hit = bus.mac_enable && (bus.tap_index == 5'd10);
    end
    checkOutput("reach_tap10", 32'(bus.tap_index), 32'd10);
    reset    = 1'b0;
    in_reset = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_mac_enable", 32'(bus.mac_enable), 32'd0);
    checkOutput("rst_tap_index", 32'(bus.tap_index), 32'd0);
    checkOutput("rst_mac_data", 32'(bus.mac_data), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    sync_cycles = 0;
    repeat (3) applyStimulus(1'b0, '0, 1'b0);
    @(negedge clk);
    reset    = 1'b1;
    in_reset = 1'b0;
    repeat (2) applyStimulus(1'b0, '0, 1'b0);
    checkOutput("rst_no_sync", 32'(sync_cycles), 32'd0);
    checkOutput("rst_fifo_empty", 32'(bus.busy), 32'd0);
    resetCounters();
    applyStimulus(1'b1, 16'h4321, 1'b0);
    t0 = t;
    drainIdle(60);
    checkOutput("rst_fresh_latency", 32'(first_en_t - t0), 32'd2);
    checkOutput("rst_fresh_en_cycles", 32'(en_cycles), 32'(NT));

    $display("[TB] strobe during FLUSH");
    resetCounters();
    applyStimulus(1'b1, 16'h0F0F, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      applyStimulus(1'b0, '0, 1'b0);
      hit = bus.mac_sync_reset;
    end
    checkOutput("flush_seen", 32'(bus.mac_sync_reset), 32'd1);
    t0 = t;
    first_en_t = -1;
    applyStimulus(1'b1, 16'hA5A5, 1'b0);
    drainIdle(60);
    checkOutput("flush_gap", 32'(first_en_t - t0), 32'd3);
    checkOutput("flush_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("flush_en_cycles", 32'(en_cycles), 32'(2 * NT));

    $display("[TB] random strobes");
    for (int k = 0; k < 600; k++) begin
      applyStimulus(bit'($urandom_range(0, 24) == 0), WL'($urandom), bit'($urandom_range(0, 59) == 0));
    end
    drainIdle(8 * FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
